// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port SRAM controller wrapper.
// Helpers take over-wide vectors plus a lane width so any geometry can reuse them.
package ram_pkg;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam int RSP_BUF_DEPTH = 2;
    localparam int MAX_W         = 512;
    localparam int MAX_LANES     = 64;
    localparam int MAX_W_IDX     = $clog2(MAX_W);
    localparam int MAX_LANE_IDX  = $clog2(MAX_LANES);

    // Expand one enable per lane into one enable per bit.
    function automatic logic [MAX_W-1:0] be2bit(input logic [MAX_LANES-1:0] be,
                                                input int byte_w);
        logic [MAX_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_W; i++)
            mask[MAX_W_IDX'(i)] = be[MAX_LANE_IDX'(i / byte_w)];
        return mask;
    endfunction

    // Even parity bit per lane; bits above the real data width must be zero.
    function automatic logic [MAX_LANES-1:0] lane_parity(input logic [MAX_W-1:0] data,
                                                         input int byte_w);
        logic [MAX_LANES-1:0] par;
        par = '0;
        for (int i = 0; i < MAX_W; i++)
            par[MAX_LANE_IDX'(i / byte_w)] = par[MAX_LANE_IDX'(i / byte_w)] ^ data[MAX_W_IDX'(i)];
        return par;
    endfunction

endpackage

// File: rtl/spram_macro.sv
// Raw single-port RAM leaf: active-low CEB/WEB/per-bit BWEB, one-cycle read.
// Behavioural array for FPGA inference; ASIC flows bind the compiled macro at this leaf.
module spram_macro #(
    parameter int W      = 64,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              ceb,
    input  logic              web,
    input  logic [W-1:0]      bweb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      d,
    output logic [W-1:0]      q
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; the controller zero-fills it instead.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web)
                mem[addr] <= (mem[addr] & bweb) | (d & ~bweb);
            else
                q <= mem[addr];
        end
    end

endmodule

// File: rtl/spram_ctrl_wrapper.sv
// SRAM controller: post-reset zero-fill, valid/ready requests with byte mask, 2-entry read buffer.
// Define SPRAM_PARITY_EN to store one even-parity bit per lane and flag mismatches on rsp_perr.
module spram_ctrl_wrapper
    import ram_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BYTE_W    = 8,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_perr,
    output logic                     init_done
);

    localparam int LANES = DATA_W / BYTE_W;
`ifdef SPRAM_PARITY_EN
    localparam int MW = DATA_W + LANES;
`else
    localparam int MW = DATA_W;
`endif
    localparam int PTR_W = $clog2(RSP_BUF_DEPTH);
    localparam int CNT_W = $clog2(RSP_BUF_DEPTH + 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_addr;
    logic              m_ceb, m_web;
    logic [MW-1:0]     m_bweb, m_d, m_q, wr_word, wr_mask;
    logic [ADDR_W-1:0] m_addr;
    logic              rd_issue, rd_p1, rd_p2, push, pop, push_perr;
    logic [MW-1:0]     push_word;
    logic [CNT_W-1:0]  buf_cnt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] buf_data [RSP_BUF_DEPTH];
    logic [RSP_BUF_DEPTH-1:0] buf_perr;
    logic [CNT_W:0]    credit_used;

`ifdef SPRAM_PARITY_EN
    assign wr_word   = {LANES'(lane_parity(MAX_W'(req_wdata), BYTE_W)), req_wdata};
    assign wr_mask   = {req_be, DATA_W'(be2bit(MAX_LANES'(req_be), BYTE_W))};
    assign push_perr = |(LANES'(lane_parity(MAX_W'(push_word[DATA_W-1:0]), BYTE_W))
                         ^ push_word[MW-1:DATA_W]);
`else
    assign wr_word   = req_wdata;
    assign wr_mask   = DATA_W'(be2bit(MAX_LANES'(req_be), BYTE_W));
    assign push_perr = 1'b0;
`endif

    // Reads in the macro pipeline hold a buffer slot, so the buffer can never overflow.
    assign credit_used = (CNT_W+1)'(buf_cnt) + (CNT_W+1)'(rd_p1) + (CNT_W+1)'(rd_p2);
    assign req_ready   = (state == ST_READY) && (credit_used < (CNT_W+1)'(RSP_BUF_DEPTH));
    assign init_done   = (state == ST_READY);
    assign rd_issue    = req_valid && req_ready && !req_we;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
            rd_p1     <= 1'b0;
        end else begin
            state <= state_next;
            rd_p1 <= rd_issue;
            if (state == ST_INIT)
                init_addr <= init_addr + ADDR_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        m_ceb      = 1'b1;
        m_web      = 1'b1;
        m_bweb     = '1;
        m_addr     = req_addr;
        m_d        = wr_word;
        unique case (state)
            ST_INIT: begin
                if (INIT_ZERO != 0) begin
                    m_ceb  = 1'b0;
                    m_web  = 1'b0;
                    m_bweb = '0;
                    m_addr = init_addr;
                    m_d    = '0;
                    if (init_addr == ADDR_W'(DEPTH - 1))
                        state_next = ST_READY;
                end else begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (req_valid && req_ready) begin
                    m_ceb  = 1'b0;
                    m_web  = ~req_we;
                    m_bweb = ~wr_mask;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    spram_macro #(.W(MW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_macro (
        .clk  (clk),
        .ceb  (m_ceb),
        .web  (m_web),
        .bweb (m_bweb),
        .addr (m_addr),
        .d    (m_d),
        .q    (m_q)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          p2;
            logic [MW-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p2    <= 1'b0;
                    q_reg <= '0;
                end else begin
                    p2 <= rd_p1;
                    if (rd_p1)
                        q_reg <= m_q;
                end
            end
            assign rd_p2     = p2;
            assign push      = p2;
            assign push_word = q_reg;
        end else begin : g_no_out_reg
            assign rd_p2     = 1'b0;
            assign push      = rd_p1;
            assign push_word = m_q;
        end
    endgenerate

    assign rsp_valid = (buf_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = buf_data[rd_ptr];
    assign rsp_perr  = rsp_valid && buf_perr[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_perr <= '0;
            for (int i = 0; i < RSP_BUF_DEPTH; i++)
                buf_data[i] <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= push_word[DATA_W-1:0];
                buf_perr[wr_ptr] <= push_perr;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
                2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_ctrl_wrapper.sv
// Self-checking bench: queue-based behavioural model compared every cycle, plus directed literals.
// Define SPRAM_PARITY_EN for both bench and RTL to exercise the parity backdoor test.
module tb_spram_ctrl_wrapper;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int BYTE_W    = 8;
    localparam int OUT_REG   = 0;
    localparam int INIT_ZERO = 1;
    localparam int LAT       = 1 + OUT_REG;
    localparam int INIT_LEN  = (INIT_ZERO != 0) ? DEPTH : 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [7:0]        req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_perr;
    logic              init_done;

    int n_checks = 0;
    int n_fail   = 0;

    spram_ctrl_wrapper #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W),
        .OUT_REG(OUT_REG), .INIT_ZERO(INIT_ZERO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_perr(rsp_perr), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory array, in-flight reads with due edge, buffered responses.
    typedef struct {
        logic [63:0] data;
        logic        perr;
        int          due;
    } rsp_t;

    logic [63:0] mmem [DEPTH];
    logic [7:0]  mcor [DEPTH];
    rsp_t        pend [$];
    rsp_t        bufq [$];
    int          edges = 0;
    bit          m_ready = 1'b0;
    bit          m_init_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            pend.delete();
            bufq.delete();
            for (int a = 0; a < DEPTH; a++) begin
                mmem[a] = '0;
                mcor[a] = '0;
            end
            m_ready     = 1'b0;
            m_init_done = 1'b0;
        end else begin
            bit hs, pp;
            hs = req_valid && m_ready;
            pp = (bufq.size() != 0) && rsp_ready;
            edges++;
            if (pp)
                void'(bufq.pop_front());
            while (pend.size() != 0 && pend[0].due <= edges)
                bufq.push_back(pend.pop_front());
            if (hs) begin
                if (req_we) begin
                    for (int l = 0; l < 8; l++)
                        if (req_be[l]) begin
                            mmem[req_addr][l*8 +: 8] = req_wdata[l*8 +: 8];
                            mcor[req_addr][l] = 1'b0;
                        end
                end else begin
                    pend.push_back('{mmem[req_addr], mcor[req_addr] != 8'h00, edges + LAT});
                end
            end
            m_init_done = edges >= INIT_LEN;
            m_ready     = m_init_done && (bufq.size() + pend.size() < 2);
        end
    end

    always @(negedge clk) begin
        check_bit("req_ready", req_ready, m_ready);
        check_bit("init_done", init_done, m_init_done);
        check_bit("rsp_valid", rsp_valid, bufq.size() != 0);
        if (bufq.size() != 0) begin
            check_word("rsp_rdata", rsp_rdata, bufq[0].data);
            check_bit("rsp_perr", rsp_perr, bufq[0].perr);
        end else begin
            check_bit("rsp_perr_idle", rsp_perr, 1'b0);
        end
    end

    logic [63:0] popped [$];
    always @(negedge clk)
        if (rst_n && rsp_valid && rsp_ready)
            popped.push_back(rsp_rdata);

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                check_bit("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [63:0] d, input logic [7:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        wait_accept();
    endtask

    task automatic wait_rsp(input string name, input logic [63:0] exp);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
            if (n > 50) begin
                check_bit("rsp_timeout", 1'b0, 1'b1);
                break;
            end
        end
        check_word(name, rsp_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values();
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_word("rst_rsp_rdata", rsp_rdata, 64'h0);
        check_bit("rst_rsp_perr", rsp_perr, 1'b0);
        check_bit("rst_init_done", init_done, 1'b0);
    endtask

    task automatic wait_init();
        repeat (DEPTH - 1) @(posedge clk);
        #1;
        check_bit("init_busy_ready", req_ready, 1'b0);
        check_bit("init_busy_done", init_done, 1'b0);
        @(posedge clk); #1;
        check_bit("init_done_17", init_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        #23;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        send(1'b0, 4'd5, '0, '0);
        wait_rsp("read_init_zero", 64'h0);

        send(1'b1, 4'd3, 64'h1122_3344_5566_7788, 8'hFF);
        send(1'b1, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        send(1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        send(1'b0, 4'd3, '0, '0);
        wait_rsp("byte_mask", 64'h1122_3344_AAAA_AAAA);

        send(1'b0, 4'd3, '0, '0);
        check_bit("lat_t0", rsp_valid, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            check_bit("lat_tk", rsp_valid, k == LAT);
        end
        repeat (3) @(posedge clk);
        #1;

        send(1'b1, 4'd0, 64'hD0D0_0000_0000_0000, 8'hFF);
        send(1'b1, 4'd1, 64'hD1D1_1111_1111_1111, 8'hFF);
        send(1'b1, 4'd2, 64'hD2D2_2222_2222_2222, 8'hFF);
        popped.delete();
        rsp_ready = 1'b0;
        send(1'b0, 4'd0, '0, '0);
        send(1'b0, 4'd1, '0, '0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd2;
        repeat (5) @(posedge clk);
        #1;
        check_bit("bp_req_ready", req_ready, 1'b0);
        check_bit("bp_rsp_valid", rsp_valid, 1'b1);
        check_word("bp_hold_data", rsp_rdata, 64'hD0D0_0000_0000_0000);
        rsp_ready = 1'b1;
        wait_accept();
        repeat (8) @(posedge clk);
        #1;
        check_word("bp_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            check_word("bp_order0", popped[0], 64'hD0D0_0000_0000_0000);
            check_word("bp_order1", popped[1], 64'hD1D1_1111_1111_1111);
            check_word("bp_order2", popped[2], 64'hD2D2_2222_2222_2222);
        end

        // Reset at init word 7.
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        // Reset with two buffered reads, then with one read in flight.
        rsp_ready = 1'b0;
        send(1'b0, 4'd4, '0, '0);
        send(1'b0, 4'd5, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_bit("buf2_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        send(1'b0, 4'd6, '0, '0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        send(1'b0, 4'd3, '0, '0);
        wait_rsp("zero_after_reset", 64'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (!req_valid || acc) begin
                req_valid = ($urandom % 4) != 0;
                req_we    = ($urandom % 2) != 0;
                req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
                req_wdata = {$urandom, $urandom};
                case ($urandom % 4)
                    0:       req_be = 8'h00;
                    1:       req_be = 8'hFF;
                    default: req_be = 8'($urandom);
                endcase
            end
            rsp_ready = ($urandom % 3) != 0;
        end
        if (req_valid)
            wait_accept();
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

`ifdef SPRAM_PARITY_EN
        send(1'b1, 4'd9, 64'h0102_0304_0506_0708, 8'hFF);
        send(1'b1, 4'd10, 64'h0A0B_0C0D_0E0F_1011, 8'hFF);
        dut.u_macro.mem[9][16] = ~dut.u_macro.mem[9][16];
        mmem[9][16] = ~mmem[9][16];
        mcor[9][2]  = 1'b1;
        send(1'b0, 4'd9, '0, '0);
        while (!rsp_valid) @(negedge clk);
        check_bit("perr_flipped", rsp_perr, 1'b1);
        @(posedge clk); #1;
        send(1'b0, 4'd10, '0, '0);
        while (!rsp_valid) @(negedge clk);
        check_bit("perr_clean", rsp_perr, 1'b0);
        @(posedge clk); #1;
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
